// File: rtl/motion_est_sad.sv
// motion_est_sad: full-search block-matching engine.
// It scans every displacement (dx,dy) in [-RANGE,+RANGE]^2 over a BLKxBLK
// reference block and reports the minimum sum of absolute differences and
// its displacement.
// Optional build macro MOTION_EST_EARLY_TERM_EN: drops a candidate as soon as
// its registered partial SAD reaches the current best SAD.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results from the previous search are held
// SCAN  | issuing one ref/search read pair per cycle, no bubbles
// DRAIN | last reads in flight; final accumulate and compare
// DONE  | one-cycle done pulse; results valid
module motion_est_sad #(
  parameter int PIX_W = 8,
  parameter int BLK   = 16,
  parameter int RANGE = 8,
  localparam int SW    = BLK + 2*RANGE,
  localparam int SAD_W = PIX_W + 2*$clog2(BLK),
  localparam int MV_W  = $clog2(2*RANGE+1) + 1,
  localparam int RA_W  = $clog2(BLK*BLK),
  localparam int SA_W  = $clog2(SW*SW)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [SAD_W-1:0]        best_sad,
  output logic signed [MV_W-1:0]  mv_x,
  output logic signed [MV_W-1:0]  mv_y,
  output logic                    rd_en,
  output logic [RA_W-1:0]         ref_addr,
  input  logic [PIX_W-1:0]        ref_data,
  output logic [SA_W-1:0]         srch_addr,
  input  logic [PIX_W-1:0]        srch_data
);

  localparam int XW = $clog2(BLK);
  localparam logic [XW-1:0]   XM = XW'(BLK-1);
  localparam logic [MV_W-1:0] CM = MV_W'(2*RANGE);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nx;

  // pixel (px,py) and candidate (cx,cy) counters; cx = dx+RANGE, cy = dy+RANGE
  logic [XW-1:0]   px, py;
  logic [MV_W-1:0] cx, cy;
  logic            last_pix, last_cand, start_acc, abort, scan_end;

  // stage 1: read issued last cycle, data valid this cycle
  logic            p1_v, p1_first, p1_last;
  logic [MV_W-1:0] p1_cx, p1_cy;

  // stage 2: registered partial/final SAD
  logic            a_v, a_fin;
  logic [MV_W-1:0] a_cx, a_cy;
  logic [SAD_W-1:0] acc;
  logic [PIX_W-1:0] diff;

  assign start_acc = (state == S_IDLE) && start;
  assign last_pix  = (px == XM) && (py == XM);
  assign last_cand = (cx == CM) && (cy == CM);
  assign scan_end  = last_cand && (last_pix || abort);

  assign ref_addr  = RA_W'({py, px});
  assign srch_addr = SA_W'((int'(py) + int'(cy)) * SW + int'(px) + int'(cx));

`ifdef MOTION_EST_EARLY_TERM_EN
  // A candidate can never win once its partial sum already reaches the best.
  // The tag match keeps the check from firing on a candidate already left.
  assign abort = (state == S_SCAN) && a_v && !a_fin &&
                 (a_cx == cx) && (a_cy == cy) && (acc >= best_sad);
`else
  assign abort = 1'b0;
`endif

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // next-state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_SCAN;
      S_SCAN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (scan_end) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // once no read is in flight the final compare happens on this edge
        if (!p1_v) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // address generator: x inner, y, then dx, dy outer; abort skips to next candidate
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      px <= '0;
      py <= '0;
      cx <= '0;
      cy <= '0;
    end else if (start_acc) begin
      px <= '0;
      py <= '0;
      cx <= '0;
      cy <= '0;
    end else if (state == S_SCAN) begin
      if (last_pix || abort) begin
        px <= '0;
        py <= '0;
        if (cx == CM) begin
          cx <= '0;
          cy <= (cy == CM) ? '0 : cy + MV_W'(1);
        end else begin
          cx <= cx + MV_W'(1);
        end
      end else begin
        px <= px + XW'(1);
        if (px == XM) py <= py + XW'(1);
      end
    end
  end

  // absolute difference of the returning pixel pair
  always_comb begin
    diff = (ref_data > srch_data) ? (ref_data - srch_data) : (srch_data - ref_data);
  end

  // read tracking: tags follow each read to the cycle its data returns
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1_v     <= 1'b0;
      p1_first <= 1'b0;
      p1_last  <= 1'b0;
      p1_cx    <= '0;
      p1_cy    <= '0;
    end else begin
      p1_v     <= rd_en && !abort;
      p1_first <= (px == '0) && (py == '0);
      p1_last  <= last_pix;
      p1_cx    <= cx;
      p1_cy    <= cy;
    end
  end

  // per-candidate accumulation, restarting on pixel 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_v   <= 1'b0;
      a_fin <= 1'b0;
      a_cx  <= '0;
      a_cy  <= '0;
      acc   <= '0;
    end else begin
      a_v <= p1_v && !abort;
      if (p1_v && !abort) begin
        acc   <= (p1_first ? '0 : acc) + SAD_W'(diff);
        a_fin <= p1_last;
        a_cx  <= p1_cx;
        a_cy  <= p1_cy;
      end
    end
  end

  // best tracking: strict less-than keeps the earliest candidate on ties
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      best_sad <= '1;
      mv_x     <= '0;
      mv_y     <= '0;
    end else if (start_acc) begin
      best_sad <= '1;
    end else if (a_v && a_fin && (acc < best_sad)) begin
      best_sad <= acc;
      mv_x     <= a_cx - MV_W'(RANGE);
      mv_y     <= a_cy - MV_W'(RANGE);
    end
  end

endmodule

// File: tb/tb_motion_est_sad.sv
// Directed bench for motion_est_sad at BLK=4, RANGE=2 (25 candidates, 400 reads).
module tb_motion_est_sad;

  localparam int PIX_W = 8;
  localparam int BLK   = 4;
  localparam int RANGE = 2;
  localparam int SW    = BLK + 2*RANGE;
  localparam int NRD   = (2*RANGE+1)*(2*RANGE+1)*BLK*BLK;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic              busy, done, rd_en;
  logic [11:0]       best_sad;
  logic signed [3:0] mv_x, mv_y;
  logic [3:0]        ref_addr;
  logic [5:0]        srch_addr;
  logic [7:0]        ref_data, srch_data;

  logic [7:0] ref_mem  [16];
  logic [7:0] srch_mem [64];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, rd_cnt = 0, done_cnt = 0, last_rd_cyc = 0;

  motion_est_sad #(.PIX_W(PIX_W), .BLK(BLK), .RANGE(RANGE)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .mv_x      (mv_x),
    .mv_y      (mv_y),
    .rd_en     (rd_en),
    .ref_addr  (ref_addr),
    .ref_data  (ref_data),
    .srch_addr (srch_addr),
    .srch_data (srch_data)
  );

  always #5 clock = ~clock;

  // synchronous memories: data valid the cycle after the read strobe
  always @(posedge clock) begin
    if (rd_en) begin
      ref_data  <= ref_mem[ref_addr];
      srch_data <= srch_mem[srch_addr];
    end
  end

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (rd_en) begin
      rd_cnt      = rd_cnt + 1;
      last_rd_cyc = cyc;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy",      busy, 0);
    check("rst_done",      done, 0);
    check("rst_rd_en",     rd_en, 0);
    check("rst_ref_addr",  ref_addr, 0);
    check("rst_srch_addr", srch_addr, 0);
    check("rst_best_sad",  best_sad, 4095);
    check("rst_mv_x",      $signed(mv_x), 0);
    check("rst_mv_y",      $signed(mv_y), 0);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", ok, 1);
  endtask

  // start one search; report reads, done latency and the first-scan-cycle status
  task automatic run_search(output int reads, output int lat, output bit b1, output bit e1);
    int r0;
    @(posedge clock); #1 start = 1'b1; r0 = rd_cnt;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    b1 = busy;
    e1 = rd_en;
    wait_done(1000);
    #1;
    reads = rd_cnt - r0;
    lat   = cyc - last_rd_cyc;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 64; i++) srch_mem[i] = 8'(((i*37 + 11) % 255) + 1);
    // reference = window patch at dx=+1, dy=-1
    for (int y = 0; y < BLK; y++)
      for (int x = 0; x < BLK; x++)
        ref_mem[y*BLK + x] = srch_mem[(y - 1 + RANGE)*SW + (x + 1 + RANGE)];
  endtask

  initial begin
    int reads, lat, r0, d0;
    bit b1, e1, ok;

    reset_n = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'd0;
    for (int i = 0; i < 64; i++) srch_mem[i] = 8'd0;
    repeat (3) @(negedge clock);
    check_reset_outputs();
    @(posedge clock); #1 reset_n = 1'b1;

    // all-zero memories: every candidate ties, earliest (-2,-2) wins
    run_search(reads, lat, b1, e1);
    check("a_busy_first",  b1, 1);
    check("a_rd_en_first", e1, 1);
    check("a_reads",       reads, NRD);
    check("a_done_lat",    lat, 3);
    check("a_best_sad",    best_sad, 0);
    check("a_mv_x",        $signed(mv_x), -2);
    check("a_mv_y",        $signed(mv_y), -2);
    @(negedge clock);
    check("a_done_width",  done, 0);
    repeat (4) @(negedge clock);
    check("a_hold_sad",    best_sad, 0);
    check("a_hold_mv_x",   $signed(mv_x), -2);

    // exact match at (+1,-1) in a window of distinct nonzero pixels
    load_pattern();
    run_search(reads, lat, b1, e1);
`ifdef MOTION_EST_EARLY_TERM_EN
    check("b_reads_below_full", (reads < NRD) ? 1 : 0, 1);
`else
    check("b_reads", reads, NRD);
    check("b_done_lat", lat, 3);
`endif
    check("b_best_sad", best_sad, 0);
    check("b_mv_x",     $signed(mv_x), 1);
    check("b_mv_y",     $signed(mv_y), -1);

    // largest possible SAD: 16*255 = 4080, no wrap
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'd255;
    for (int i = 0; i < 64; i++) srch_mem[i] = 8'd0;
    run_search(reads, lat, b1, e1);
    check("c_best_sad", best_sad, 4080);
    check("c_mv_x",     $signed(mv_x), -2);
    check("c_mv_y",     $signed(mv_y), -2);

    // start re-pulsed during the search must be ignored
    load_pattern();
    d0 = done_cnt;
    r0 = rd_cnt;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (194) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done(1000);
    repeat (40) @(negedge clock);
    #1;
    check("d_done_count", done_cnt - d0, 1);
`ifndef MOTION_EST_EARLY_TERM_EN
    check("d_reads", rd_cnt - r0, NRD);
`endif
    check("d_best_sad", best_sad, 0);
    check("d_mv_x",     $signed(mv_x), 1);
    check("d_mv_y",     $signed(mv_y), -1);

    // reset at read 100 aborts with no done; next search starts right after release
    d0 = done_cnt;
    @(posedge clock); #1 start = 1'b1; r0 = rd_cnt;
    @(posedge clock); #1 start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock); #1;
      if (rd_cnt - r0 >= 100) begin
        ok = 1'b1;
        break;
      end
    end
    check("e_reached_read100", ok, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (5) @(negedge clock);
    check("e_no_done", done_cnt - d0, 0);
    @(posedge clock); #1 reset_n = 1'b1; start = 1'b1;
    r0 = rd_cnt;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    check("e_busy_after_release", busy, 1);
    wait_done(1000);
    #1;
`ifndef MOTION_EST_EARLY_TERM_EN
    check("e_reads", rd_cnt - r0, NRD);
`endif
    check("e_best_sad", best_sad, 0);
    check("e_mv_x",     $signed(mv_x), 1);
    check("e_mv_y",     $signed(mv_y), -1);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_est_sad.md
MOTION_EST_SAD -- requirements
Module: motion_est_sad

Interface
REQ-001 SHALL have parameter PIX_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter BLK, default 16: reference block edge in pixels; power of two, 2..16.
REQ-003 SHALL have parameter RANGE, default 8: search displacement ±RANGE per axis; 0..15. Window edge SW = BLK+2*RANGE.
REQ-004 SHALL use derived widths SAD_W = PIX_W+2*log2(BLK) and MV_W = clog2(2*RANGE+1)+1 (signed).
REQ-005 SHALL have port clock, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: request one full search; sampled only in IDLE.
REQ-008 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when results are valid.
REQ-010 SHALL have port best_sad, output, SAD_W: minimum SAD found.
REQ-011 SHALL have ports mv_x and mv_y, output, MV_W each: signed displacement of best_sad.
REQ-012 SHALL have port rd_en, output, 1: read strobe for both memories.
REQ-013 SHALL have ports ref_addr, output, clog2(BLK*BLK), and ref_data, input, PIX_W: reference memory, address y*BLK+x.
REQ-014 SHALL have ports srch_addr, output, clog2(SW*SW), and srch_data, input, PIX_W: search memory, address (y+dy+RANGE)*SW+(x+dx+RANGE).

Function
REQ-015 SHALL implement FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE; IDLE->SCAN on start, SCAN->DRAIN after the last read, DRAIN->DONE once the last candidate is compared, DONE->IDLE unconditionally.
REQ-016 SHALL scan candidates dy outer, dx inner, each from -RANGE to +RANGE, and pixels y outer, x inner, 0..BLK-1.
REQ-017 SHALL issue reads back-to-back across candidate boundaries, one pixel pair per rd_en cycle, without bubbles.
REQ-018 SHALL treat ref_data/srch_data as valid exactly one cycle after the rd_en cycle.
REQ-019 SHALL accumulate |ref-srch| per candidate, restarting on pixel 0; SAD_W guarantees no overflow and needs no saturation.
REQ-020 SHALL update best only on strict less-than, so ties keep the earliest candidate in scan order.
REQ-021 SHALL load best_sad with all ones at start acceptance.
REQ-022 Without early termination, rd_en SHALL be high for exactly (2*RANGE+1)^2*BLK^2 consecutive cycles beginning the cycle after start is accepted.
REQ-023 done SHALL rise on the third cycle after the last rd_en cycle.
REQ-024 best_sad, mv_x and mv_y SHALL hold from done until the next start is accepted.
REQ-025 start SHALL be ignored while busy or done is high.
REQ-026 RANGE=0 SHALL yield a single candidate with mv (0,0).

Reset
REQ-027 While reset_n is low, the FSM SHALL be in IDLE and outputs SHALL be: busy=0, done=0, rd_en=0, addresses=0, best_sad=all ones, mv_x=mv_y=0.
REQ-028 Reset mid-search SHALL abort immediately with no done pulse; a new start SHALL be accepted the first cycle after release.

Configuration
REQ-029 Macro MOTION_EST_EARLY_TERM_EN, when defined, SHALL abort a candidate once its registered partial SAD is >= best_sad.
REQ-030 On abort, the address generator SHALL move to the next candidate's pixel 0 on the next cycle, and the in-flight read of the aborted candidate SHALL be discarded.
REQ-031 Early termination SHALL NOT change the final best_sad, mv_x or mv_y.
REQ-032 Without the macro, the REQ-022 read count SHALL be exact and no abort logic SHALL exist.

Verification (BLK=4, RANGE=2: 25 candidates, 400 reads, SAD_W=12, MV_W=4)
REQ-033 All memories zero, start -> 400 rd_en cycles, done on the 3rd cycle after the last read, best_sad=0, mv=(-2,-2).
REQ-034 Reference equals window patch at (dx=+1, dy=-1), window otherwise random 1..255 -> best_sad=0, mv_x=+1, mv_y=-1.
REQ-035 Reference all 255, window all 0 -> best_sad=4080, mv=(-2,-2), no wrap.
REQ-036 start re-pulsed at cycles 5 and 200 of a search -> ignored, one done only; reset_n low at read 100 -> no done, outputs at reset values, next search correct.
REQ-037 REQ-034 stimulus with MOTION_EST_EARLY_TERM_EN -> fewer than 400 rd_en cycles, identical results; without the macro -> exactly 400.
